pipeline_stall_ctrl: RTL and testbench

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_stall_ctrl.sv | 123 ++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall controller for a five-stage pipeline.
// Resolves taken branches, load-use hazards and multi-cycle mul/div ops in
// Execute. Stall/flush outputs are combinational so a hazard is handled in
// the same cycle it appears; only the FSM, its down-counter and the stall
// statistics counter are registered.
module pipeline_stall_ctrl #(
    parameter int unsigned MDU_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ResultSrcE0,
    input  logic [4:0]  RdE,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic        PCSrcE,
    input  logic        MulDivE,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushM,
    output logic        mdu_start,
    output logic        mdu_busy,
    output logic [15:0] stall_count
);

    typedef enum logic {
        RUN = 1'b0,
        MDU = 1'b1
    } state_t;

    // The start cycle in RUN and the release cycle in MDU each account for
    // one cycle of occupancy, so the counter covers the remaining MDU_LAT-2.
    localparam logic [7:0] CNT_INIT = 8'(MDU_LAT - 2);

    state_t     state;
    logic [7:0] cnt;
    logic       load_use;

    // A load whose destination feeds either Decode source; x0 never matters.
    assign load_use = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // Combinational hazard decisions, all forced low while reset is held.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        mdu_start = 1'b0;
        mdu_busy  = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (PCSrcE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (MulDivE) begin
                        mdu_start = 1'b1;
                        StallF    = 1'b1;
                        StallD    = 1'b1;
                        StallE    = 1'b1;
                        FlushM    = 1'b1;
                    end else if (load_use) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                MDU: begin
                    mdu_busy = 1'b1;
                    if (cnt != 8'd0) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // FSM and occupancy counter: enter MDU on a start, leave when cnt hits 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= 8'd0;
        end else begin
            case (state)
                RUN: begin
                    if (!PCSrcE && MulDivE) begin
                        state <= MDU;
                        cnt   <= CNT_INIT;
                    end
                end
                MDU: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which Fetch was held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= 16'd0;
        end else if (StallF && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Self-checking bench for pipeline_stall_ctrl (MDU_LAT = 4).
// A cycle-level model tracks how far into a multi-cycle op Execute is and
// derives the expected stall/flush pattern and stall count from that.
module tb_pipeline_stall_ctrl;

    localparam int MDU_LAT = 4;

    // Output vector order: {StallF,StallD,StallE,FlushD,FlushE,FlushM,mdu_start,mdu_busy}
    localparam logic [7:0] V_IDLE   = 8'b0000_0000;
    localparam logic [7:0] V_BRANCH = 8'b0001_1000;
    localparam logic [7:0] V_START  = 8'b1110_0110;
    localparam logic [7:0] V_HOLD   = 8'b1110_0101;
    localparam logic [7:0] V_REL    = 8'b0000_0001;
    localparam logic [7:0] V_LU     = 8'b1100_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ResultSrcE0;
    logic [4:0]  RdE;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic        PCSrcE;
    logic        MulDivE;
    logic        StallF;
    logic        StallD;
    logic        StallE;
    logic        FlushD;
    logic        FlushE;
    logic        FlushM;
    logic        mdu_start;
    logic        mdu_busy;
    logic [15:0] stall_count;
    logic [7:0]  out_vec;

    int          checks = 0;
    int          failures = 0;

    // Model state: 0 = not in an op, k = currently in cycle k of an op.
    int          age = 0;
    logic [15:0] m_count = 16'd0;

    pipeline_stall_ctrl #(.MDU_LAT(MDU_LAT)) dut (
        .clk         (clk),
        .rst         (rst),
        .ResultSrcE0 (ResultSrcE0),
        .RdE         (RdE),
        .Rs1D        (Rs1D),
        .Rs2D        (Rs2D),
        .PCSrcE      (PCSrcE),
        .MulDivE     (MulDivE),
        .StallF      (StallF),
        .StallD      (StallD),
        .StallE      (StallE),
        .FlushD      (FlushD),
        .FlushE      (FlushE),
        .FlushM      (FlushM),
        .mdu_start   (mdu_start),
        .mdu_busy    (mdu_busy),
        .stall_count (stall_count)
    );

    assign out_vec = {StallF, StallD, StallE, FlushD, FlushE, FlushM, mdu_start, mdu_busy};

    // Free-running clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    // Expected outputs for the current cycle from the behavioural rules.
    function automatic logic [7:0] model_vec(input int a, input logic r, input logic pc,
                                             input logic md, input logic rse,
                                             input logic [4:0] rd, input logic [4:0] s1,
                                             input logic [4:0] s2);
        logic lu;
        lu = rse && (rd != 5'd0) && ((rd == s1) || (rd == s2));
        if (!r)                return V_IDLE;
        if (a == 0) begin
            if (pc)            return V_BRANCH;
            if (md)            return V_START;
            if (lu)            return V_LU;
            return V_IDLE;
        end
        if (a < MDU_LAT)       return V_HOLD;
        return V_REL;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input logic r, input logic pc, input logic md, input logic rse,
                                 input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
        @(posedge clk);
        #1;
        rst         = r;
        PCSrcE      = pc;
        MulDivE     = md;
        ResultSrcE0 = rse;
        RdE         = rd;
        Rs1D        = s1;
        Rs2D        = s2;
    endtask

    // Advance the model at each edge; reset clears it asynchronously.
    always @(posedge clk or negedge rst) begin
        logic [7:0] v;
        if (!rst) begin
            age     = 0;
            m_count = 16'd0;
        end else begin
            v = model_vec(age, rst, PCSrcE, MulDivE, ResultSrcE0, RdE, Rs1D, Rs2D);
            if (v[7] && (m_count != 16'hFFFF)) m_count = m_count + 16'd1;
            if (age == 0)              age = v[1] ? 2 : 0;
            else if (age >= MDU_LAT)   age = 0;
            else                       age = age + 1;
        end
    end

    // Compare DUT against the model every cycle, mid-cycle.
    always @(negedge clk) begin
        checkOutput("model_outputs", {8'h00, out_vec},
                    {8'h00, model_vec(age, rst, PCSrcE, MulDivE, ResultSrcE0, RdE, Rs1D, Rs2D)});
        checkOutput("model_count", stall_count, m_count);
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        rst = 1'b0; PCSrcE = 1'b1; MulDivE = 1'b1; ResultSrcE0 = 1'b1;
        RdE = 5'd5; Rs1D = 5'd5; Rs2D = 5'd5;
        #3;
        checkOutput("reset_outputs", {8'h00, out_vec}, 16'h0000);
        checkOutput("reset_count", stall_count, 16'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5); #2;
        checkOutput("reset_hold_outputs", {8'h00, out_vec}, 16'h0000);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("idle_after_reset", {8'h00, out_vec}, {8'h00, V_IDLE});

        // Load-use through Rs2D.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 5'd1, 5'd5); #2;
        checkOutput("load_use_rs2", {8'h00, out_vec}, {8'h00, V_LU});
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("load_use_count", stall_count, 16'd1);

        // x0 destination never stalls.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("x0_filter", {8'h00, out_vec}, {8'h00, V_IDLE});
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("x0_count", stall_count, 16'd1);

        // Load-use through Rs1D, and a matching non-load.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd3); #2;
        checkOutput("load_use_rs1", {8'h00, out_vec}, {8'h00, V_LU});
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd7); #2;
        checkOutput("non_load_match", {8'h00, out_vec}, {8'h00, V_IDLE});

        // Branch beats mul/div and load-use; no op starts.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 5'd9, 5'd9); #2;
        checkOutput("priority_branch", {8'h00, out_vec}, {8'h00, V_BRANCH});
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("priority_stays_run", {8'h00, out_vec}, {8'h00, V_IDLE});

        // Single multi-cycle op; a branch during MDU is ignored.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("mdu_start_cycle", {8'h00, out_vec}, {8'h00, V_START});
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 5'd4, 5'd0); #2;
        checkOutput("mdu_hold_ignore_branch", {8'h00, out_vec}, {8'h00, V_HOLD});
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("mdu_hold_2", {8'h00, out_vec}, {8'h00, V_HOLD});
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("mdu_release", {8'h00, out_vec}, {8'h00, V_REL});
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("mdu_after", {8'h00, out_vec}, {8'h00, V_IDLE});
        checkOutput("mdu_count", stall_count, 16'd5);

        // Back-to-back ops with MulDivE held for two full occupancies.
        for (int i = 1; i <= 2 * MDU_LAT; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0); #2;
            if (i == MDU_LAT)     checkOutput("b2b_release", {8'h00, out_vec}, {8'h00, V_REL});
            if (i == MDU_LAT + 1) checkOutput("b2b_restart", {8'h00, out_vec}, {8'h00, V_START});
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("b2b_count", stall_count, 16'd11);

        // Reset during the second cycle of an op.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("pre_abort_start", {8'h00, out_vec}, {8'h00, V_START});
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0); #1;
        checkOutput("abort_outputs", {8'h00, out_vec}, 16'h0000);
        checkOutput("abort_count", stall_count, 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("post_abort_idle", {8'h00, out_vec}, {8'h00, V_IDLE});
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("post_abort_start", {8'h00, out_vec}, {8'h00, V_START});
        for (int i = 0; i < MDU_LAT; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        end
        #2;
        checkOutput("post_abort_count", stall_count, 16'd3);

        // Saturation: sustained load-use stall well past 65535 cycles.
        for (int i = 0; i < 65540; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("saturate_count", stall_count, 16'hFFFF);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 5'd0, 5'd9); #2;
        checkOutput("saturate_stall", {8'h00, out_vec}, {8'h00, V_LU});
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); #2;
        checkOutput("saturate_hold", stall_count, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
